// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the 8-bit ALU: register file, operand muxes, registered ALU bundle.
// Define ALU_OPERAND_FETCH_BYPASS_EN for write-first forwarding of same-edge write-back data.
module alu_operand_fetch #(
  parameter int NREGS = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ISSUE_VALID,
  output logic             ISSUE_READY,
  input  logic [2:0]       ALUOP,
  input  logic [AW-1:0]    RS1,
  input  logic [AW-1:0]    RS2,
  input  logic [AW-1:0]    RD,
  input  logic             SRC2_IMM,
  input  logic [WIDTH-1:0] IMM,
  input  logic             NEG_SRC2,
  output logic [WIDTH-1:0] DATA1,
  output logic [WIDTH-1:0] DATA2,
  output logic [2:0]       SELECT,
  output logic             OP_VALID,
  output logic [AW-1:0]    OP_RD,
  input  logic             OP_READY,
  input  logic             WB_EN,
  input  logic [AW-1:0]    WB_ADDR,
  input  logic [WIDTH-1:0] WB_DATA
);

  // Two's-complement negate, wrapping modulo 2^WIDTH (the most negative value maps to itself).
  function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
    return -v;
  endfunction

  logic        [WIDTH-1:0] regs [NREGS];
  logic        [WIDTH-1:0] rd1;
  logic        [WIDTH-1:0] rd2;
  logic signed [WIDTH-1:0] src2;
  logic signed [WIDTH-1:0] opnd2;
  logic                    accept;

  logic        [WIDTH-1:0] data1_p0;
  logic signed [WIDTH-1:0] data2_p0;
  logic        [2:0]       sel_p0;
  logic        [AW-1:0]    rd_p0;
  logic                    vld_p0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WB_EN) begin
      regs[WB_ADDR] <= WB_DATA;
    end
  end

  always_comb begin
    rd1 = regs[RS1];
    rd2 = regs[RS2];
`ifdef ALU_OPERAND_FETCH_BYPASS_EN
    if (WB_EN && (WB_ADDR == RS1)) rd1 = WB_DATA;
    if (WB_EN && (WB_ADDR == RS2)) rd2 = WB_DATA;
`endif
    src2  = SRC2_IMM ? IMM : rd2;
    opnd2 = NEG_SRC2 ? negate(src2) : src2;
  end

  assign ISSUE_READY = !vld_p0 || OP_READY;
  assign accept      = ISSUE_VALID && ISSUE_READY;

  // Stage p0: registered bundle presented to the ALU
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data1_p0 <= '0;
      data2_p0 <= '0;
      sel_p0   <= '0;
      rd_p0    <= '0;
      vld_p0   <= 1'b0;
    end else if (accept) begin
      data1_p0 <= rd1;
      data2_p0 <= opnd2;
      sel_p0   <= ALUOP;
      rd_p0    <= RD;
      vld_p0   <= 1'b1;
    end else if (OP_READY) begin
      vld_p0   <= 1'b0;
    end
  end

  assign DATA1    = data1_p0;
  assign DATA2    = data2_p0;
  assign SELECT   = sel_p0;
  assign OP_RD    = rd_p0;
  assign OP_VALID = vld_p0;

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch stage directly upstream of the 8-bit ALU. Holds the 8×8 register file, reads two source operands, applies the immediate and negate muxes, and presents a registered DATA1/DATA2/SELECT bundle to the ALU with a valid/ready handshake. ALU results return through the write-back port and are written into the register file.

## Interface
- NREGS, 8, number of registers; the address width is log2(NREGS).
- WIDTH, 8, data width; it matches the ALU DATA1/DATA2/RESULT width.

- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset. The block is in reset while RESET=0.
- ISSUE_VALID  in  1  an operation is presented on the issue inputs.
- ISSUE_READY  out  1  the stage can accept an operation this cycle.
- ALUOP  in  3  ALU select code, forwarded unchanged to SELECT (000 FWD, 001 ADD, 010 AND, 011 OR).
- RS1  in  3  source register for DATA1.
- RS2  in  3  source register for DATA2 when SRC2_IMM=0.
- RD  in  3  destination tag, forwarded to OP_RD.
- SRC2_IMM  in  1  1 selects IMM as the second operand; 0 selects R[RS2].
- IMM  in  WIDTH  immediate operand.
- NEG_SRC2  in  1  1 replaces the second operand with its two's complement.
- DATA1  out  WIDTH  operand 1 to the ALU.
- DATA2  out  WIDTH  operand 2 to the ALU.
- SELECT  out  3  ALU select.
- OP_VALID  out  1  the output bundle is valid.
- OP_RD  out  3  destination tag of the output bundle.
- OP_READY  in  1  the downstream stage consumes the bundle.
- WB_EN  in  1  register write enable.
- WB_ADDR  in  3  write address.
- WB_DATA  in  WIDTH  write data (the ALU RESULT).

## Operation
- Register file:
  - NREGS×WIDTH flops, all writable; no hardwired zero register.
  - When WB_EN=1, R[WB_ADDR] is written with WB_DATA at the rising edge.
- Issue handshake:
  - ISSUE_READY = !OP_VALID || OP_READY. It is combinational and independent of ISSUE_VALID.
  - An operation is accepted at a rising edge where ISSUE_VALID && ISSUE_READY.
- Operand formation on accept:
  - src1 = R[RS1].
  - src2 = SRC2_IMM ? IMM : R[RS2].
  - DATA1 ← src1.
  - DATA2 ← NEG_SRC2 ? (~src2 + 1) mod 2^WIDTH : src2. For example, 0x00 negates to 0x00 and 0x80 negates to 0x80.
  - SELECT ← ALUOP, OP_RD ← RD, OP_VALID ← 1.
- Output bundle:
  - If there is no accept and OP_VALID && OP_READY, then OP_VALID ← 0. DATA1, DATA2, SELECT and OP_RD keep their last values.
  - While OP_VALID && !OP_READY, DATA1, DATA2, SELECT and OP_RD are held stable.
- Write-back is independent of the handshake. It is accepted every cycle, including cycles where the output is stalled.
- ALUOP values 100–111 are forwarded unchanged; the ALU defines their result.

## Timing
- Reset values (asynchronous, while RESET=0):
  - All R[i]=0.
  - DATA1=0, DATA2=0, SELECT=000, OP_RD=000, OP_VALID=0.
  - ISSUE_READY=1.
- Reset mid-operation: any pending bundle is dropped. Writes and issues presented during reset are ignored.
- The first accept can occur at the first rising edge after RESET goes high.
- Latency: an operation accepted at edge N appears on DATA1/DATA2/SELECT with OP_VALID=1 immediately after edge N. The ALU RESULT follows combinationally.
- Throughput: one operation per cycle when OP_READY is held at 1.
- Write-to-read ordering:
  - A write at edge N is visible to any issue accepted at edge N+1 or later.
  - A write and an issue at the same edge with WB_ADDR matching RS1, or matching RS2 with SRC2_IMM=0, is governed by Configuration.
- Consume and refill at the same edge: the new bundle replaces the old one and OP_VALID stays 1.

## Configuration
- Macro: ALU_OPERAND_FETCH_BYPASS_EN.
- Defined: write-first forwarding. A same-edge write to a source register supplies WB_DATA as the operand. NEG_SRC2 is applied after forwarding.
- Undefined: read-before-write. The same-edge issue captures the old register value, and the new value is visible from the next accept.
- All other behaviour is identical in both builds.

## Test plan
- Reset hold and release: assert RESET=0 mid-stream with OP_VALID=1 → OP_VALID=0, DATA1=DATA2=0, SELECT=000 immediately. After release, issue FWD of RS1=R5 → DATA1=0x00.
- Write then add: write R1=0x0F and R2=0xF1 on separate cycles, then issue ADD RS1=1 RS2=2 → DATA1=0x0F, DATA2=0xF1, SELECT=001, OP_VALID=1 after one edge.
- Immediate with negate: R3=0x05, issue ADD RS1=3 SRC2_IMM=1 IMM=0x03 NEG_SRC2=1 → DATA2=0xFD. Repeat with IMM=0x80 → DATA2=0x80.
- Stall: hold OP_READY=0 with OP_VALID=1 and ISSUE_VALID=1 for 3 cycles → ISSUE_READY=0 and outputs unchanged. Raise OP_READY → the next bundle loads at that edge and OP_VALID stays 1.
- Same-edge hazard: R4=0x11, then WB R4=0x22 at the same edge as issue RS1=4 → DATA1=0x22 with ALU_OPERAND_FETCH_BYPASS_EN defined, 0x11 without it. The next issue of RS1=4 yields 0x22 in both builds.
- Back-to-back: OP_READY=1 and four consecutive issues (FWD, ADD, AND, OR) → four consecutive valid bundles with SELECT 000, 001, 010, 011 and no bubbles.
